fetch_prefetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end: generates sequential PCs, issues pipelined

---
 rtl/fetch_prefetch_queue.sv | 95 +++++++++
 tb/tb_fetch_prefetch_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential-PC fetch front end with credit-limited pipelined memory
// requests, an in-order PC tag FIFO and a DEPTH-entry prefetch queue feeding decode.
module fetch_prefetch_queue #(
  parameter int PC_W = 16,
  parameter int INSTR_W = 16,
  parameter int DEPTH = 4,
  parameter int PC_INC = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pc_next,
  output logic               err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PC_W:0] INC = (PC_W + 1)'(PC_INC);
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d, disc_q, disc_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic err_q, err_d;
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_q [DEPTH];
  logic [PC_W-1:0] tag_mem_q [DEPTH];
  logic issue, rv, push, pop;
  logic [PC_W:0] pc_sum;
  // outst counts every response still due, including those already marked for discard
  always_comb begin
    imem_req = rst_n && !halt && !redirect && (({1'b0, count_q} + {1'b0, outst_q}) < {1'b0, DEPTH_C});
    imem_addr = fetch_pc_q;
    issue = imem_req && imem_gnt;
    rv = imem_rvalid && outst_q != '0;
    push = rv && !redirect && disc_q == '0;
    out_valid = count_q != '0;
    pop = out_valid && out_ready && !redirect;
    pc_sum = {1'b0, fetch_pc_q} + INC;
    fetch_pc_d = redirect ? redirect_pc : issue ? pc_sum[PC_W-1:0] : fetch_pc_q;
    err_d = err_q || (issue && pc_sum[PC_W]);
    outst_d = outst_q + CW'(issue) - CW'(rv);
    disc_d = redirect ? outst_d : (rv && disc_q != '0) ? disc_q - CW'(1) : disc_q;
    count_d = redirect ? '0 : count_q + CW'(push) - CW'(pop);
    head_d = redirect ? '0 : head_q + AW'(pop);
    tail_d = redirect ? '0 : tail_q + AW'(push);
    tag_wr_d = tag_wr_q + AW'(issue);
    tag_rd_d = tag_rd_q + AW'(rv);
    out_instr = out_valid ? instr_mem_q[head_q] : '0;
    out_pc = out_valid ? pc_mem_q[head_q] : '0;
    out_pc_next = out_valid ? pc_mem_q[head_q] + PC_W'(PC_INC) : '0;
    err = err_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      count_q <= '0;
      outst_q <= '0;
      disc_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      err_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q <= count_d;
      outst_q <= outst_d;
      disc_q <= disc_d;
      head_q <= head_d;
      tail_q <= tail_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      err_q <= err_d;
    end
  end
  // storage needs no reset: contents are only visible through out_valid-gated outputs
  always_ff @(posedge clk) begin
    if (issue) tag_mem_q[tag_wr_q] <= fetch_pc_q;
    if (push) begin
      instr_mem_q[tail_q] <= imem_rdata;
      pc_mem_q[tail_q] <= tag_mem_q[tag_rd_q];
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: directed stimulus with an in-bench memory, a queue-level
// reference model checked every cycle, and literal expectations at key points.
`timescale 1ns/1ps
module tb_fetch_prefetch_queue;
  localparam int DEPTH = 4;
  typedef struct {logic [15:0] a; int due;} mreq_t;
  typedef struct {logic [15:0] pc; bit drop;} fly_t;
  typedef struct {logic [15:0] instr; logic [15:0] pc;} ent_t;
  logic clk = 0, rst_n = 0;
  logic redirect = 0, halt = 0, imem_gnt = 1, imem_rvalid = 0, out_ready = 1;
  logic [15:0] redirect_pc = 16'h0, imem_rdata = 16'h0;
  logic imem_req, out_valid, err;
  logic [15:0] imem_addr, out_instr, out_pc, out_pc_next;
  logic req2, valid2, err2;
  logic [15:0] addr2, instr2, pc2, pcn2;
  int lat = 1, cyc = 0, n_tests = 0, n_fail = 0;
  mreq_t mem[$];
  fly_t fly[$];
  ent_t oq[$];
  logic [15:0] m_pc = 16'h0;
  logic m_err = 1'b0;

  always #5 clk = ~clk;

  fetch_prefetch_queue dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_next(out_pc_next), .err(err));

  fetch_prefetch_queue #(.RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .rst_n(rst_n), .redirect(1'b0), .redirect_pc(16'h0), .halt(1'b0),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(1'b1),
    .imem_rvalid(1'b0), .imem_rdata(16'h0), .out_valid(valid2),
    .out_ready(1'b1), .out_instr(instr2), .out_pc(pc2),
    .out_pc_next(pcn2), .err(err2));

  function automatic logic [15:0] mem_data(logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  function automatic bit model_req();
    return rst_n && !halt && !redirect && (oq.size() + fly.size() < DEPTH);
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory environment plus reference model, both advanced on each rising edge
  always begin : model
    bit rv, iss, pop;
    fly_t f;
    @(posedge clk);
    if (!rst_n) begin
      mem.delete(); fly.delete(); oq.delete();
      m_pc = 16'h0;
      m_err = 1'b0;
    end else begin
      rv = imem_rvalid && fly.size() != 0;
      iss = model_req() && imem_gnt;
      pop = oq.size() != 0 && out_ready && !redirect;
      if (imem_rvalid && mem.size() != 0) mem.delete(0);
      if (imem_req && imem_gnt) mem.push_back('{imem_addr, cyc + lat});
      if (pop) oq.delete(0);
      if (rv) begin
        f = fly[0];
        fly.delete(0);
        if (!f.drop && !redirect) oq.push_back('{imem_rdata, f.pc});
      end
      if (redirect) begin
        oq.delete();
        foreach (fly[i]) fly[i].drop = 1'b1;
        m_pc = redirect_pc;
      end
      if (iss) begin
        fly.push_back('{m_pc, 1'b0});
        if (32'(m_pc) + 32'd2 > 32'hFFFF) m_err = 1'b1;
        m_pc = m_pc + 16'd2;
      end
      cyc++;
    end
    #1;
    imem_rvalid = mem.size() != 0 && mem[0].due <= cyc;
    imem_rdata = imem_rvalid ? mem_data(mem[0].a) : 16'h0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_req", 16'(imem_req), 16'h0);
      check("rst_valid", 16'(out_valid), 16'h0);
      check("rst_instr", out_instr, 16'h0);
      check("rst_pc", out_pc, 16'h0);
      check("rst_pc_next", out_pc_next, 16'h0);
      check("rst_err", 16'(err), 16'h0);
    end else begin
      check("req", 16'(imem_req), 16'(model_req()));
      if (model_req()) check("addr", imem_addr, m_pc);
      check("valid", 16'(out_valid), 16'(oq.size() != 0));
      if (oq.size() != 0) begin
        check("instr", out_instr, oq[0].instr);
        check("pc", out_pc, oq[0].pc);
        check("pc_next", out_pc_next, oq[0].pc + 16'd2);
      end
      check("err", 16'(err), 16'(m_err));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int l);
    nxt();
    rst_n = 0; lat = l; halt = 0; redirect = 0; imem_gnt = 1; out_ready = 1;
    @(negedge clk);
    check("lit_rst_err", 16'(err), 16'h0);
    check("lit_rst_err2", 16'(err2), 16'h0);
    nxt(); nxt();
    rst_n = 1;
  endtask

  initial begin
    // streaming with 1-cycle memory
    do_reset(1);
    @(negedge clk);
    check("t1_addr0", imem_addr, 16'h0000);
    check("t1_req", 16'(imem_req), 16'h1);
    check("t1_w_addr0", addr2, 16'hFFFE);
    check("t1_w_err0", 16'(err2), 16'h0);
    nxt(); @(negedge clk);
    check("t1_addr1", imem_addr, 16'h0002);
    check("t1_w_addr1", addr2, 16'h0000);
    check("t1_w_err1", 16'(err2), 16'h1);
    nxt(); @(negedge clk);
    check("t1_pc0", out_pc, 16'h0000);
    check("t1_next0", out_pc_next, 16'h0002);
    check("t1_instr0", out_instr, 16'hC3A5);
    nxt(); @(negedge clk);
    check("t1_pc1", out_pc, 16'h0002);
    check("t1_instr1", out_instr, 16'hC3A7);
    nxt(); @(negedge clk);
    check("t1_pc2", out_pc, 16'h0004);
    check("t1_w_err_hold", 16'(err2), 16'h1);
    // decode stalled: credit limit stops issue after DEPTH requests
    do_reset(1);
    out_ready = 0;
    repeat (7) nxt();
    @(negedge clk);
    check("t2_req_off", 16'(imem_req), 16'h0);
    check("t2_valid", 16'(out_valid), 16'h1);
    check("t2_pc_hold", out_pc, 16'h0000);
    nxt(); out_ready = 1;
    @(negedge clk);
    check("t2_pc_resume0", out_pc, 16'h0000);
    nxt(); @(negedge clk);
    check("t2_pc_resume1", out_pc, 16'h0002);
    check("t2_addr_resume", imem_addr, 16'h0008);
    // redirect with three requests in flight, 3-cycle memory
    do_reset(3);
    nxt(); nxt(); nxt();
    redirect = 1; redirect_pc = 16'h0100;
    @(negedge clk);
    check("t3_req_kill", 16'(imem_req), 16'h0);
    nxt(); redirect = 0;
    @(negedge clk);
    check("t3_addr", imem_addr, 16'h0100);
    check("t3_flushed", 16'(out_valid), 16'h0);
    repeat (4) nxt();
    @(negedge clk);
    check("t3_valid", 16'(out_valid), 16'h1);
    check("t3_pc", out_pc, 16'h0100);
    check("t3_instr", out_instr, 16'hC2A5);
    // redirect coinciding with a response and a pop
    do_reset(1);
    nxt(); nxt(); nxt();
    redirect = 1; redirect_pc = 16'h0200;
    @(negedge clk);
    check("t4_pre_pc", out_pc, 16'h0002);
    nxt(); redirect = 0;
    @(negedge clk);
    check("t4_empty", 16'(out_valid), 16'h0);
    check("t4_addr", imem_addr, 16'h0200);
    nxt(); nxt();
    @(negedge clk);
    check("t4_pc", out_pc, 16'h0200);
    // back-to-back redirects under halt, then PC wrap
    nxt(); redirect = 1; redirect_pc = 16'h1234; halt = 1;
    nxt(); redirect_pc = 16'hFFFE;
    nxt(); redirect = 0;
    @(negedge clk);
    check("t5_halt_req", 16'(imem_req), 16'h0);
    nxt(); halt = 0;
    @(negedge clk);
    check("t5_addr_last", imem_addr, 16'hFFFE);
    check("t5_err0", 16'(err), 16'h0);
    nxt(); @(negedge clk);
    check("t5_addr_wrap", imem_addr, 16'h0000);
    check("t5_err1", 16'(err), 16'h1);
    repeat (3) nxt();
    @(negedge clk);
    check("t5_err_sticky", 16'(err), 16'h1);
    // halt with two requests outstanding
    do_reset(3);
    nxt(); nxt();
    halt = 1;
    @(negedge clk);
    check("t6_req_off", 16'(imem_req), 16'h0);
    nxt(); nxt();
    @(negedge clk);
    check("t6_pc0", out_pc, 16'h0000);
    nxt(); @(negedge clk);
    check("t6_pc1", out_pc, 16'h0002);
    nxt(); @(negedge clk);
    check("t6_drained", 16'(out_valid), 16'h0);
    check("t6_req_still_off", 16'(imem_req), 16'h0);
    // mixed back-pressure, grant gaps and a mid-stream redirect
    halt = 0;
    for (int i = 0; i < 40; i++) begin
      nxt();
      out_ready = (i % 3) != 0;
      imem_gnt = (i % 5) != 1;
      redirect = i == 20;
      redirect_pc = 16'h0400;
    end
    nxt();
    redirect = 0;
    repeat (6) nxt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
